// File: rtl/denise_colortable_ram_pipe.sv
// Byte-enabled simple-dual-port palette RAM with a post-reset clear
// sequencer, per-byte write-to-read bypass and an optional output register.
//
// Ports:
//   clock, reset     rising-edge clock, synchronous active-high reset
//   enable           clock enable; holds memory, pipeline and sequencer
//   wren, byteena_a  write request and per-byte lane enables
//   wraddress, data  write address and write data
//   rden, rdaddress  read request and read address
//   q, q_valid       read data and one-cycle result strobe
//   busy             high while the clear sequencer runs
module denise_colortable_ram_pipe #(
  parameter int                 BYTES      = 4,
  parameter int                 ADDR_W     = 8,
  parameter bit                 OUT_REG    = 1'b1,
  parameter logic [8*BYTES-1:0] INIT_VALUE = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 wren,
  input  logic [BYTES-1:0]     byteena_a,
  input  logic [ADDR_W-1:0]    wraddress,
  input  logic [8*BYTES-1:0]   data,
  input  logic                 rden,
  input  logic [ADDR_W-1:0]    rdaddress,
  output logic [8*BYTES-1:0]   q,
  output logic                 q_valid,
  output logic                 busy
);

  localparam int DW    = 8 * BYTES;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic [DW-1:0]     mem [DEPTH];
  logic [DW-1:0]     rd_word;
  logic [DW-1:0]     s1_data;
  logic              s1_valid;
  logic              hit;

  assign busy = (state == CLEAR);
  assign hit  = wren && (wraddress == rdaddress);

  // New-data semantics on collision, resolved per byte lane.
  always_comb begin
    rd_word = mem[rdaddress];
    if (hit) begin
      for (int i = 0; i < BYTES; i++) begin
        if (byteena_a[i]) begin
          rd_word[8*i +: 8] = data[8*i +: 8];
        end
      end
    end
  end

  // Memory has no reset of its own; the sequencer overwrites it.
  always_ff @(posedge clock) begin
    if (!reset && enable) begin
      if (state == CLEAR) begin
        mem[clr_addr] <= INIT_VALUE;
      end else if (wren) begin
        for (int i = 0; i < BYTES; i++) begin
          if (byteena_a[i]) begin
            mem[wraddress][8*i +: 8] <= data[8*i +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= CLEAR;
      clr_addr <= '0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (enable) begin
      if (state == CLEAR) begin
        clr_addr <= clr_addr + 1'b1;
        if (clr_addr == LAST) begin
          state <= RUN;
        end
      end
      s1_valid <= rden;
      // Reads during clear return the fill colour whatever memory holds.
      if (rden) begin
        s1_data <= (state == CLEAR) ? INIT_VALUE : rd_word;
      end
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [DW-1:0] s2_data;
      logic          s2_valid;

      always_ff @(posedge clock) begin
        if (reset) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
        end else if (enable) begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign q       = s2_data;
      assign q_valid = s2_valid;
    end else begin : g_out_direct
      assign q       = s1_data;
      assign q_valid = s1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_denise_colortable_ram_pipe.sv
// Directed bench: two instances (OUT_REG=1 with zero fill, OUT_REG=0
// with a non-zero fill) share one stimulus stream.
module tb_denise_colortable_ram_pipe;

  localparam logic [31:0] INIT0 = 32'hC0FFEE11;

  logic        clock = 1'b0;
  logic        reset, enable, wren, rden;
  logic [3:0]  byteena_a;
  logic [7:0]  wraddress, rdaddress;
  logic [31:0] data;
  logic [31:0] q1, q0;
  logic        qv1, qv0, busy1, busy0;

  int tests = 0;
  int fails = 0;
  int n;

  always #5 clock = ~clock;

  denise_colortable_ram_pipe #(
    .BYTES(4), .ADDR_W(8), .OUT_REG(1'b1), .INIT_VALUE(32'h0)
  ) u1 (
    .clock(clock), .reset(reset), .enable(enable),
    .wren(wren), .byteena_a(byteena_a),
    .wraddress(wraddress), .data(data),
    .rden(rden), .rdaddress(rdaddress),
    .q(q1), .q_valid(qv1), .busy(busy1)
  );

  denise_colortable_ram_pipe #(
    .BYTES(4), .ADDR_W(8), .OUT_REG(1'b0), .INIT_VALUE(INIT0)
  ) u0 (
    .clock(clock), .reset(reset), .enable(enable),
    .wren(wren), .byteena_a(byteena_a),
    .wraddress(wraddress), .data(data),
    .rden(rden), .rdaddress(rdaddress),
    .q(q0), .q_valid(qv0), .busy(busy0)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    wren = 1'b1; wraddress = a; data = d; byteena_a = be;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; wren = 1'b0; rden = 1'b0;
    byteena_a = 4'h0; wraddress = 8'h0; rdaddress = 8'h0; data = 32'h0;
    step(); step();
    chk("rst_q1", q1, 32'h0);
    chk("rst_qv1", {31'b0, qv1}, 32'h0);
    chk("rst_busy1", {31'b0, busy1}, 32'h1);
    chk("rst_q0", q0, 32'h0);
    chk("rst_busy0", {31'b0, busy0}, 32'h1);

    reset = 1'b0;
    n = 0;
    while (busy1 && n < 400) begin step(); n++; end
    chk("clr_len", n, 256);
    chk("clr_busy0", {31'b0, busy0}, 32'h0);

    rden = 1'b1; rdaddress = 8'hFF;
    step(); rden = 1'b0;
    chk("rdff_q0", q0, INIT0);
    chk("rdff_qv0", {31'b0, qv0}, 32'h1);
    chk("rdff_qv1_early", {31'b0, qv1}, 32'h0);
    step();
    chk("rdff_q1", q1, 32'h0);
    chk("rdff_qv1", {31'b0, qv1}, 32'h1);
    chk("rdff_qv0_drop", {31'b0, qv0}, 32'h0);

    wr(8'h10, 32'hAABBCCDD, 4'hF);
    step(); wren = 1'b0;
    rden = 1'b1; rdaddress = 8'h10;
    step(); rden = 1'b0;
    chk("full_q0", q0, 32'hAABBCCDD);
    chk("full_qv0", {31'b0, qv0}, 32'h1);
    step();
    chk("full_q1", q1, 32'hAABBCCDD);
    chk("full_qv1", {31'b0, qv1}, 32'h1);

    wr(8'h10, 32'h11223344, 4'b0101);
    step(); wren = 1'b0;
    rden = 1'b1; rdaddress = 8'h10;
    step(); rden = 1'b0;
    chk("part_q0", q0, 32'hAA22CC44);
    step();
    chk("part_q1", q1, 32'hAA22CC44);

    wr(8'h20, 32'hFFFFFFFF, 4'b1000);
    rden = 1'b1; rdaddress = 8'h20;
    step(); wren = 1'b0; rden = 1'b0;
    chk("coll_q0", q0, 32'hFFFFEE11);
    step();
    chk("coll_q1", q1, 32'hFF000000);

    rden = 1'b1; rdaddress = 8'h10;
    step();
    chk("b2b_q0_a", q0, 32'hAA22CC44);
    rdaddress = 8'h20;
    step();
    chk("b2b_q0_b", q0, 32'hFFFFEE11);
    chk("b2b_q1_a", q1, 32'hAA22CC44);
    chk("b2b_qv1_a", {31'b0, qv1}, 32'h1);
    rden = 1'b0;
    step();
    chk("b2b_q1_b", q1, 32'hFF000000);
    chk("b2b_qv1_b", {31'b0, qv1}, 32'h1);
    chk("b2b_qv0_end", {31'b0, qv0}, 32'h0);

    rden = 1'b1; rdaddress = 8'h10;
    step();
    enable = 1'b0; rden = 1'b0;
    wr(8'h10, 32'h0, 4'hF);
    for (int i = 0; i < 5; i++) step();
    chk("stall_q0", q0, 32'hAA22CC44);
    chk("stall_qv0", {31'b0, qv0}, 32'h1);
    chk("stall_q1", q1, 32'hFF000000);
    chk("stall_qv1", {31'b0, qv1}, 32'h0);
    enable = 1'b1; wren = 1'b0;
    step();
    chk("unstall_q1", q1, 32'hAA22CC44);
    chk("unstall_qv1", {31'b0, qv1}, 32'h1);
    chk("unstall_qv0", {31'b0, qv0}, 32'h0);
    rden = 1'b1; rdaddress = 8'h10;
    step(); rden = 1'b0;
    chk("nowr_q0", q0, 32'hAA22CC44);
    step();
    chk("nowr_q1", q1, 32'hAA22CC44);

    rden = 1'b1; rdaddress = 8'h10;
    step();
    rdaddress = 8'h20;
    step();
    chk("fly_qv1", {31'b0, qv1}, 32'h1);
    rden = 1'b0; reset = 1'b1;
    step(); reset = 1'b0;
    chk("fly_rst_qv1", {31'b0, qv1}, 32'h0);
    chk("fly_rst_qv0", {31'b0, qv0}, 32'h0);
    chk("fly_rst_busy", {31'b0, busy1}, 32'h1);

    for (int i = 0; i < 100; i++) step();
    chk("mid_busy", {31'b0, busy1}, 32'h1);
    reset = 1'b1;
    step(); reset = 1'b0;
    chk("mid_rst_busy", {31'b0, busy0}, 32'h1);

    rden = 1'b1; rdaddress = 8'h10;
    step(); rden = 1'b0;
    chk("clr_rd_q0", q0, INIT0);
    chk("clr_rd_qv0", {31'b0, qv0}, 32'h1);
    step();
    chk("clr_rd_qv1", {31'b0, qv1}, 32'h1);
    n = 2;
    while (n < 255) begin step(); n++; end
    chk("clr2_busy_hi", {31'b0, busy1}, 32'h1);
    wr(8'h10, 32'h55555555, 4'hF);
    step(); wren = 1'b0; n++;
    chk("clr2_len", n, 256);
    chk("clr2_busy1", {31'b0, busy1}, 32'h0);
    chk("clr2_busy0", {31'b0, busy0}, 32'h0);
    rden = 1'b1; rdaddress = 8'h10;
    step(); rden = 1'b0;
    chk("lost_q0", q0, INIT0);
    step();
    chk("lost_q1", q1, 32'h0);
    chk("lost_qv1", {31'b0, qv1}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
